// File: rtl/iq_pkg.sv
// Shared types for the issue queue: per-entry state and the tag storage type.
package iq_pkg;

  typedef enum logic [1:0] {
    ENT_FREE  = 2'd0,
    ENT_WAIT  = 2'd1,
    ENT_READY = 2'd2
  } ent_state_e;

  // Tags are stored zero-extended to this width so the type can live here
  // independent of the TagWidth parameter; unused upper bits hold constant 0.
  localparam int unsigned IQ_TAG_W_MAX = 16;

  typedef logic [IQ_TAG_W_MAX-1:0] iq_tag_t;

endpackage

// File: rtl/iq_free_picker.sv
// Picks the k-th lowest-index free entry for each enqueue lane and counts
// how many entries are free.
module iq_free_picker #(
  parameter int unsigned EntryCount = 8,
  parameter int unsigned EnqWidth   = 2,
  parameter int unsigned CntW       = $clog2(EntryCount + 1)
) (
  input  logic [EntryCount-1:0]               i_free_mask,
  output logic [EnqWidth-1:0][EntryCount-1:0] o_pick_mask,
  output logic [CntW-1:0]                     o_free_cnt
);

  // Peel off the lowest set bit once per lane so lane k lands on the k-th free entry.
  always_comb begin : pick
    logic [EntryCount-1:0] remain;
    remain = i_free_mask;
    for (int k = 0; k < int'(EnqWidth); k++) begin
      o_pick_mask[k] = remain & (-remain);
      remain         = remain & ~o_pick_mask[k];
    end
  end

  // Population count of free entries.
  always_comb begin
    o_free_cnt = '0;
    for (int e = 0; e < int'(EntryCount); e++) begin
      o_free_cnt = o_free_cnt + CntW'(i_free_mask[e]);
    end
  end

endmodule

// File: rtl/issue_queue_ctrl.sv
// Issue queue control: allocates entries for enqueue lanes, tracks operand
// wakeup per entry, forwards age-selector picks to issue ports and frees
// entries on accepted issues.
module issue_queue_ctrl
  import iq_pkg::*;
#(
  parameter int unsigned EntryCount = 8,
  parameter int unsigned EnqWidth   = 2,
  parameter int unsigned SelWidth   = 2,
  parameter int unsigned TagWidth   = 6,
  localparam int unsigned CntW      = $clog2(EntryCount + 1)
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                flush_i,
  input  logic [EnqWidth-1:0]                 enq_vld_i,
  output logic [EnqWidth-1:0]                 enq_rdy_o,
  input  logic [EnqWidth-1:0]                 enq_src_rdy_i,
  input  logic [EnqWidth-1:0][TagWidth-1:0]   enq_src_tag_i,
  input  logic                                wakeup_vld_i,
  input  logic [TagWidth-1:0]                 wakeup_tag_i,
  output logic [SelWidth-1:0]                 issue_vld_o,
  output logic [SelWidth-1:0][EntryCount-1:0] issue_mask_o,
  input  logic [SelWidth-1:0]                 issue_rdy_i,
  output logic [EnqWidth-1:0]                 sel_enq_fire_o,
  output logic [EnqWidth-1:0][EntryCount-1:0] sel_enq_mask_o,
  output logic                                sel_deq_fire_o,
  output logic [EntryCount-1:0]               sel_deq_mask_o,
  output logic [EntryCount-1:0]               sel_sel_mask_o,
  output logic [EntryCount-1:0]               sel_entry_vld_o,
  input  logic [SelWidth-1:0][EntryCount-1:0] sel_result_mask_i,
  output logic [CntW-1:0]                     count_o
);

  ent_state_e r_state [EntryCount];
  iq_tag_t    r_tag   [EntryCount];
  logic [CntW-1:0] r_count;

  logic [EntryCount-1:0]               w_free_mask;
  logic [EnqWidth-1:0][EntryCount-1:0] w_pick;
  logic [CntW-1:0]                     w_free_cnt;
  logic [EnqWidth-1:0]                 w_enq_fire;
  logic [EnqWidth-1:0]                 w_lane_ready;
  logic [EntryCount-1:0]               w_alloc;
  logic [EntryCount-1:0]               w_alloc_ready;
  iq_tag_t                             w_alloc_tag [EntryCount];
  logic [EntryCount-1:0]               w_wk_hit;
  logic [SelWidth-1:0]                 w_iss_fire;
  logic                                w_ctrl_en;
  logic [CntW-1:0]                     w_enq_cnt;
  logic [CntW-1:0]                     w_deq_cnt;
  iq_tag_t                             w_wk_tag;

  assign w_ctrl_en = rstn & ~flush_i;
  assign w_wk_tag  = iq_tag_t'(wakeup_tag_i);

  // Entry status views for the picker and the age selector.
  always_comb begin
    for (int e = 0; e < int'(EntryCount); e++) begin
      w_free_mask[e]     = (r_state[e] == ENT_FREE);
      sel_sel_mask_o[e]  = (r_state[e] == ENT_READY);
      sel_entry_vld_o[e] = (r_state[e] != ENT_FREE);
      w_wk_hit[e]        = wakeup_vld_i & (r_state[e] == ENT_WAIT) & (r_tag[e] == w_wk_tag);
    end
  end

  iq_free_picker #(
    .EntryCount (EntryCount),
    .EnqWidth   (EnqWidth),
    .CntW       (CntW)
  ) u_free_picker (
    .i_free_mask (w_free_mask),
    .o_pick_mask (w_pick),
    .o_free_cnt  (w_free_cnt)
  );

  // Enqueue handshake and per-entry allocation targets.
  always_comb begin
    w_enq_cnt = '0;
    w_alloc   = '0;
    w_alloc_ready = '0;
    for (int e = 0; e < int'(EntryCount); e++) begin
      w_alloc_tag[e] = '0;
    end
    for (int k = 0; k < int'(EnqWidth); k++) begin
      enq_rdy_o[k]      = w_ctrl_en & (w_free_cnt > CntW'(k));
      w_enq_fire[k]     = enq_vld_i[k] & enq_rdy_o[k];
      sel_enq_mask_o[k] = w_enq_fire[k] ? w_pick[k] : '0;
      w_lane_ready[k]   = enq_src_rdy_i[k] |
                          (wakeup_vld_i & (wakeup_tag_i == enq_src_tag_i[k]));
      w_enq_cnt         = w_enq_cnt + CntW'(w_enq_fire[k]);
      for (int e = 0; e < int'(EntryCount); e++) begin
        if (sel_enq_mask_o[k][e]) begin
          w_alloc[e]       = 1'b1;
          w_alloc_ready[e] = w_lane_ready[k];
          w_alloc_tag[e]   = iq_tag_t'(enq_src_tag_i[k]);
        end
      end
    end
    sel_enq_fire_o = w_enq_fire;
  end

  // Issue ports follow the selector picks; accepted picks form the dequeue mask.
  always_comb begin
    sel_deq_mask_o = '0;
    for (int p = 0; p < int'(SelWidth); p++) begin
      issue_mask_o[p] = w_ctrl_en ? sel_result_mask_i[p] : '0;
      issue_vld_o[p]  = |issue_mask_o[p];
      w_iss_fire[p]   = issue_vld_o[p] & issue_rdy_i[p];
      if (w_iss_fire[p]) begin
        sel_deq_mask_o = sel_deq_mask_o | issue_mask_o[p];
      end
    end
    sel_deq_fire_o = |sel_deq_mask_o;
  end

  // Only occupied entries decrement the count, so a stray pick cannot wrap it.
  always_comb begin
    w_deq_cnt = '0;
    for (int e = 0; e < int'(EntryCount); e++) begin
      w_deq_cnt = w_deq_cnt + CntW'(sel_deq_mask_o[e] & sel_entry_vld_o[e]);
    end
  end

  // Entry state, tag and occupancy update.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_count <= '0;
      for (int e = 0; e < int'(EntryCount); e++) begin
        r_state[e] <= ENT_FREE;
        r_tag[e]   <= '0;
      end
    end else if (flush_i) begin
      r_count <= '0;
      for (int e = 0; e < int'(EntryCount); e++) begin
        r_state[e] <= ENT_FREE;
      end
    end else begin
      r_count <= r_count + w_enq_cnt - w_deq_cnt;
      for (int e = 0; e < int'(EntryCount); e++) begin
        if (sel_deq_mask_o[e]) begin
          r_state[e] <= ENT_FREE;
        end else if (w_alloc[e]) begin
          r_state[e] <= w_alloc_ready[e] ? ENT_READY : ENT_WAIT;
          r_tag[e]   <= w_alloc_tag[e];
        end else if (w_wk_hit[e]) begin
          r_state[e] <= ENT_READY;
        end
      end
    end
  end

  assign count_o = r_count;

endmodule
